// File: rtl/alu_arbiter_if.sv
// Bus between two requesters, the arbiter and the shared registered add/sub datapath.
// The arbiter uses the slave view; requesters plus datapath sit on the master side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;
    logic [WIDTH-1:0] alu_operand1;
    logic [WIDTH-1:0] alu_operand2;
    logic             alu_op_sel;
    logic [WIDTH-1:0] alu_data_out;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_data_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy,
        output alu_operand1, alu_operand2, alu_op_sel
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_data_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, busy,
        input  alu_operand1, alu_operand2, alu_op_sel
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered add/sub datapath between two requesters,
// one transaction in flight at a time: IDLE (arbitrate) -> EXEC (wait latency) -> RESP (hand back).
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] rsp_q, rsp_d;
    logic             grant;

    // Only a tie consults the pointer; a lone valid always wins.
    always_comb grant = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel_q   <= sel_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel_d   = sel_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_ready || bus.req1_ready) begin
                    owner_d = grant;
                    op1_d   = grant ? bus.req1_a  : bus.req0_a;
                    op2_d   = grant ? bus.req1_b  : bus.req0_b;
                    sel_d   = grant ? bus.req1_op : bus.req0_op;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == LAT_CNT) begin
                    rsp_d   = bus.alu_data_out;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    rr_d    = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (state_q == IDLE && rst) begin
            bus.req0_ready = !grant && bus.req0_valid;
            bus.req1_ready =  grant && bus.req1_valid;
        end
        bus.rsp0_valid = (state_q == RESP) && !owner_q;
        bus.rsp1_valid = (state_q == RESP) &&  owner_q;
        bus.busy       = (state_q != IDLE);
    end

    assign bus.rsp_data     = rsp_q;
    assign bus.alu_operand1 = op1_q;
    assign bus.alu_operand2 = op2_q;
    assign bus.alu_op_sel   = sel_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a LAT=1 and a LAT=3 instance, each with a behavioural datapath;
// expected results are queued at request handshake and checked when the response appears.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) ifa ();
    alu_arbiter_if #(.WIDTH(W)) ifb ();

    alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    alu_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        return op ? a + b : a - b;
    endfunction

    // Datapath models: one register stage for dut_a, three for dut_b.
    logic [W-1:0] dpa_q  = '0;
    logic [W-1:0] dpb1_q = '0;
    logic [W-1:0] dpb2_q = '0;
    logic [W-1:0] dpb3_q = '0;
    always @(posedge clk) begin
        dpa_q  <= model(ifa.alu_operand1, ifa.alu_operand2, ifa.alu_op_sel);
        dpb1_q <= model(ifb.alu_operand1, ifb.alu_operand2, ifb.alu_op_sel);
        dpb2_q <= dpb1_q;
        dpb3_q <= dpb2_q;
    end
    assign ifa.alu_data_out = dpa_q;
    assign ifb.alu_data_out = dpb3_q;

    typedef struct packed {
        logic         who;
        logic [W-1:0] data;
    } exp_t;

    typedef struct packed {
        logic         rdy0;
        logic         rdy1;
        logic         rv0;
        logic         rv1;
        logic         busy;
        logic [W-1:0] data;
    } obs_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic obs_t snap(input bit sel);
        obs_t o;
        if (sel) begin
            o.rdy0 = ifb.req0_ready; o.rdy1 = ifb.req1_ready;
            o.rv0  = ifb.rsp0_valid; o.rv1  = ifb.rsp1_valid;
            o.busy = ifb.busy;       o.data = ifb.rsp_data;
        end else begin
            o.rdy0 = ifa.req0_ready; o.rdy1 = ifa.req1_ready;
            o.rv0  = ifa.rsp0_valid; o.rv1  = ifa.rsp1_valid;
            o.busy = ifa.busy;       o.data = ifa.rsp_data;
        end
        return o;
    endfunction

    task automatic set_req(input bit sel, input bit n, input bit v,
                           input logic [W-1:0] a, input logic [W-1:0] b, input bit op);
        if (!sel && !n) begin ifa.req0_valid = v; ifa.req0_a = a; ifa.req0_b = b; ifa.req0_op = op; end
        if (!sel &&  n) begin ifa.req1_valid = v; ifa.req1_a = a; ifa.req1_b = b; ifa.req1_op = op; end
        if ( sel && !n) begin ifb.req0_valid = v; ifb.req0_a = a; ifb.req0_b = b; ifb.req0_op = op; end
        if ( sel &&  n) begin ifb.req1_valid = v; ifb.req1_a = a; ifb.req1_b = b; ifb.req1_op = op; end
    endtask

    // Wait for a request handshake, check the grant, queue the expected result.
    // Returns in the first EXEC cycle with the granted valid dropped.
    task automatic wait_hs(input bit sel, input bit exp_who, input logic [W-1:0] exp_data,
                           input string tag, output int n);
        obs_t o;
        #1;
        n = 0;
        o = snap(sel);
        while (!(o.rdy0 || o.rdy1) && n < 20) begin
            @(posedge clk); #3;
            n++;
            o = snap(sel);
        end
        chk({tag, "_hs_seen"}, 32'(n < 20), 32'd1);
        chk({tag, "_one_ready"}, 32'(o.rdy0 && o.rdy1), 32'd0);
        chk({tag, "_grant"}, 32'(o.rdy1), 32'(exp_who));
        sb.push_back('{who: exp_who, data: exp_data});
        @(posedge clk); #3;
        set_req(sel, exp_who, 1'b0, '0, '0, 1'b0);
    endtask

    // Wait for the response; lat_exp counts cycles from the handshake edge.
    task automatic wait_rsp(input bit sel, input string tag, input int lat_exp);
        obs_t o;
        exp_t e;
        int   n = 1;
        o = snap(sel);
        while (!(o.rv0 || o.rv1) && n < 40) begin
            @(posedge clk); #3;
            n++;
            o = snap(sel);
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat_exp));
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_owner"}, 32'(o.rv1), 32'(e.who));
        chk({tag, "_both_rsp"}, 32'(o.rv0 && o.rv1), 32'd0);
        chk({tag, "_data"}, o.data, e.data);
        chk({tag, "_busy"}, 32'(o.busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        int   n;
        set_req(0, 0, 0, '0, '0, 0); set_req(0, 1, 0, '0, '0, 0);
        set_req(1, 0, 0, '0, '0, 0); set_req(1, 1, 0, '0, '0, 0);
        ifa.rsp0_ready = 1; ifa.rsp1_ready = 1;
        ifb.rsp0_ready = 1; ifb.rsp1_ready = 1;

        // Reset state with req0 already pending, then first transaction.
        set_req(0, 0, 1, 32'h12345678, 32'h87654321, 1);
        repeat (2) @(posedge clk);
        #3;
        o = snap(0);
        chk("rst_ready0", 32'(o.rdy0), 32'd0);
        chk("rst_busy", 32'(o.busy), 32'd0);
        chk("rst_rsp_valid", 32'(o.rv0 | o.rv1), 32'd0);
        chk("rst_rsp_data", o.data, 32'd0);
        chk("rst_operand1", ifa.alu_operand1, 32'd0);
        chk("rst_op_sel", 32'(ifa.alu_op_sel), 32'd0);
        rst = 1;
        wait_hs(0, 0, 32'h99999999, "t1", n);
        chk("t1_first_idle", 32'(n), 32'd0);
        wait_rsp(0, "t1", 3);

        // Tie from reset: req0 first, then req1 with wraparound.
        rst = 0;
        @(posedge clk); #3;
        set_req(0, 0, 1, 32'h87654321, 32'h12345678, 0);
        set_req(0, 1, 1, 32'hFFFFFFFF, 32'h00000001, 1);
        rst = 1;
        wait_hs(0, 0, 32'h7530ECA9, "t2a", n);
        wait_rsp(0, "t2a", 3);
        wait_hs(0, 1, 32'h00000000, "t2b", n);
        chk("t2b_next_idle", 32'(n), 32'd1);
        wait_rsp(0, "t2b", 3);

        // req1 alone with borrow wrap.
        set_req(0, 1, 1, 32'h00000000, 32'h00000001, 0);
        wait_hs(0, 1, 32'hFFFFFFFF, "t3", n);
        wait_rsp(0, "t3", 3);

        // Tie goes to req0, then back-pressure on its response.
        set_req(0, 0, 1, 32'h5, 32'h7, 1);
        set_req(0, 1, 1, 32'h10, 32'h3, 0);
        ifa.rsp0_ready = 0;
        wait_hs(0, 0, 32'hC, "t4a", n);
        wait_rsp(0, "t4a", 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #3;
            o = snap(0);
            chk("t4_hold_valid", 32'(o.rv0), 32'd1);
            chk("t4_hold_data", o.data, 32'hC);
            chk("t4_hold_ready1", 32'(o.rdy1), 32'd0);
            chk("t4_hold_busy", 32'(o.busy), 32'd1);
        end
        ifa.rsp0_ready = 1;
        wait_hs(0, 1, 32'hD, "t4b", n);
        chk("t4b_next_idle", 32'(n), 32'd1);
        wait_rsp(0, "t4b", 3);

        // Move pointer to 1, then reset in the middle of a req1 transaction.
        set_req(0, 0, 1, 32'h100, 32'h1, 1);
        wait_hs(0, 0, 32'h101, "t5p", n);
        wait_rsp(0, "t5p", 3);
        set_req(0, 1, 1, 32'hAAAA0000, 32'h5555, 1);
        wait_hs(0, 1, 32'hAAAA5555, "t5x", n);
        void'(sb.pop_back());
        rst = 0;
        #1;
        o = snap(0);
        chk("t5_rst_busy", 32'(o.busy), 32'd0);
        chk("t5_rst_data", o.data, 32'd0);
        chk("t5_rst_operand1", ifa.alu_operand1, 32'd0);
        chk("t5_rst_operand2", ifa.alu_operand2, 32'd0);
        chk("t5_rst_op_sel", 32'(ifa.alu_op_sel), 32'd0);
        @(posedge clk); #3;
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #3;
            o = snap(0);
            chk("t5_no_rsp", 32'(o.rv0 | o.rv1), 32'd0);
            chk("t5_idle", 32'(o.busy), 32'd0);
        end
        set_req(0, 0, 1, 32'h3, 32'h4, 1);
        set_req(0, 1, 1, 32'h9, 32'h9, 1);
        wait_hs(0, 0, 32'h7, "t5a", n);
        wait_rsp(0, "t5a", 3);
        wait_hs(0, 1, 32'h12, "t5b", n);
        wait_rsp(0, "t5b", 3);

        // Longer datapath latency.
        set_req(1, 0, 1, 32'h0, 32'h0, 1);
        wait_hs(1, 0, 32'h0, "t6a", n);
        wait_rsp(1, "t6a", 5);
        set_req(1, 1, 1, 32'h40, 32'h2, 1);
        wait_hs(1, 1, 32'h42, "t6b", n);
        wait_rsp(1, "t6b", 5);

        @(posedge clk); #3;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single registered add/sub datapath (`code`: operand1, operand2, op_sel, data_out) between two requesters.
- Each requester submits an operand pair and an opcode with a valid/ready handshake. The block drives the datapath, waits out its latency, and returns the result on a per-requester response handshake.
- Sits directly in front of the `code` instance; one transaction is in flight at a time.

Parameters:
- WIDTH, 32, data width of operands and result.
- ALU_LAT, 1, cycles from the datapath sampling its operands to data_out valid (registered datapath = 1); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  1  requester 0 opcode: 1 = A+B, 0 = A-B.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result available for requester 1.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_data  out  WIDTH  result; shared bus, qualified by rsp0_valid or rsp1_valid.
- busy  out  1  high whenever the FSM is not in IDLE.
- alu_operand1  out  WIDTH  to datapath operand1.
- alu_operand2  out  WIDTH  to datapath operand2.
- alu_op_sel  out  1  to datapath op_sel.
- alu_data_out  in  WIDTH  from datapath data_out.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, including rsp_data, alu_operand1/2 and alu_op_sel. Any in-flight transaction is discarded and no response is issued.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = requester with valid high; if both are valid, grant = rr_ptr.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. This is combinational, and at most one ready is high per cycle.
  - On handshake at edge T: latch a, b, op into alu_operand1/2 and alu_op_sel, record owner, clear the latency counter, go to EXEC.
  - With no valid request, stay in IDLE and hold the alu_* outputs at their last values.
- EXEC:
  - alu_* outputs stay stable for the whole state.
  - The counter increments each cycle. When the counter reaches ALU_LAT, capture alu_data_out into rsp_data at that edge and go to RESP.
  - EXEC therefore lasts ALU_LAT+1 cycles. With the default, the result is captured at the end of cycle T+2 and rspN_valid rises in cycle T+3.
- RESP:
  - rsp<owner>_valid=1; the other response valid stays 0.
  - rsp_data and the alu_* outputs are held stable until the handshake.
  - On rsp<owner>_ready=1: clear valid, set rr_ptr = 1-owner, go to IDLE.
  - A new request can be accepted in the cycle after the response handshake, not in the same cycle. Minimum spacing is ALU_LAT+3 cycles per transaction.
- Arithmetic: performed by the datapath modulo 2^WIDTH. There is no carry or borrow output; the block passes the result through unchanged.
- rspN_ready while the matching rspN_valid=0: ignored.
- reqN_valid dropped before ready: no effect, and no grant is remembered.
- The pointer updates only on completed responses. Back-to-back requests from both requesters therefore alternate 0, 1, 0, 1.
- busy=0 only in IDLE.

Test Plan:
- Release reset with req0 (a=0x12345678, b=0x87654321, op=1) pending -> req0_ready in the first IDLE cycle; rsp0_valid 3 cycles after the handshake (ALU_LAT=1) with rsp_data=0x99999999; rsp1_valid stays 0.
- Simultaneous req0 (0x87654321 - 0x12345678) and req1 (0xFFFFFFFF + 0x00000001), both held valid, from reset -> req0 is served first with rsp_data=0x7530ECA9, then req1 with rsp_data=0x00000000 (wrap); ready is never high for both in one cycle.
- req1 alone: 0x00000000 - 0x00000001 -> rsp1_valid with rsp_data=0xFFFFFFFF; the next tie is granted to req0.
- Back-pressure: hold rsp0_ready=0 for 5 cycles in RESP while req1_valid=1 -> rsp0_valid and rsp_data stay stable, req1_ready stays 0, busy=1; after the ready, req1 is granted in the following IDLE cycle.
- Assert rst=0 mid-EXEC -> all outputs go to 0 immediately and asynchronously; after release no rsp valid appears for the dropped request, and rr_ptr=0.
- Parameter sweep ALU_LAT=3 with a delayed datapath model -> rsp valid 5 cycles after the handshake, with the correct sum 0x00000000+0x00000000=0x00000000.
